// File: rtl/sweep_pkg.sv
// Shared types and constants for the counter_298A sweep sequencer.
package sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN
    } state_t;

    localparam logic [1:0] ADDR_LO   = 2'd0;
    localparam logic [1:0] ADDR_HI   = 2'd1;
    localparam logic [1:0] ADDR_REPS = 2'd2;
    localparam logic [1:0] ADDR_MODE = 2'd3;

    localparam int MODE_DIR = 0;
    localparam int MODE_PP  = 1;
    localparam int MODE_OE  = 2;

    localparam logic [7:0] LO_RST   = 8'h00;
    localparam logic [7:0] HI_RST   = 8'hFF;
    localparam logic [7:0] REPS_RST = 8'h00;
    localparam logic [2:0] MODE_RST = 3'b001;

endpackage

// File: rtl/sweep_cfg_regs.sv
// Sweep configuration registers (LO, HI, REPS, MODE); writes are locked out while a sequence runs.
module sweep_cfg_regs
    import sweep_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             busy,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] reps,
    output logic [2:0]       mode
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lo   <= WIDTH'(LO_RST);
            hi   <= WIDTH'(HI_RST);
            reps <= WIDTH'(REPS_RST);
            mode <= MODE_RST;
        end else if (cfg_we && !busy) begin
            case (cfg_addr)
                ADDR_LO:   lo   <= cfg_data;
                ADDR_HI:   hi   <= cfg_data;
                ADDR_REPS: reps <= cfg_data;
                ADDR_MODE: mode <= cfg_data[2:0];
                default:   ;
            endcase
        end
    end

endmodule

// File: rtl/counter_298a_sweep_ctrl.sv
// Sweep sequencer driving counter_298A: ping-pong or sawtooth between LO and HI, using y as feedback.
module counter_298a_sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_en,
    output logic             cnt_load,
    output logic             cnt_up,
    output logic             cnt_oe,
    output logic [WIDTH-1:0] cnt_d,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state;
    logic             dir;
    logic [7:0]       sweep_cnt;
    logic [WIDTH-1:0] lo, hi, reps;
    logic [2:0]       mode;

    sweep_cfg_regs #(.WIDTH(WIDTH)) u_regs (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .busy     (busy),
        .lo       (lo),
        .hi       (hi),
        .reps     (reps),
        .mode     (mode)
    );

    logic       terminal;
    logic [7:0] sweep_next;
    logic [7:0] reps8;
    logic       finish;

    assign terminal   = dir ? (cnt_q == hi) : (cnt_q == lo);
    assign sweep_next = sweep_cnt + 8'd1;
    assign reps8      = 8'(reps);
    // REPS of zero never finishes; the sweep counter simply wraps.
    assign finish     = (reps8 != 8'd0) && (sweep_next == reps8);

    always_comb begin
        cnt_en   = 1'b0;
        cnt_load = 1'b0;
        cnt_up   = 1'b0;
        cnt_oe   = 1'b0;
        cnt_d    = '0;
        case (state)
            ST_IDLE: cnt_oe = mode[MODE_OE];
            ST_LOAD: begin
                if (!stop) begin
                    cnt_load = 1'b1;
                    cnt_d    = dir ? lo : hi;
                    cnt_oe   = 1'b1;
                end
            end
            ST_RUN: begin
                if (!stop && !(terminal && finish)) begin
                    cnt_oe = 1'b1;
                    if (!terminal) begin
                        cnt_en = 1'b1;
                        cnt_up = dir;
                    end else if (mode[MODE_PP]) begin
                        // Turn around in place: the bound shows for a single cycle.
                        cnt_en = (lo != hi);
                        cnt_up = ~dir;
                    end else begin
                        cnt_load = 1'b1;
                        cnt_d    = dir ? lo : hi;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            dir       <= 1'b0;
            sweep_cnt <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !cfg_we) begin
                        if (lo > hi) begin
                            err <= 1'b1;
                        end else begin
                            dir       <= mode[MODE_DIR];
                            sweep_cnt <= 8'd0;
                            state     <= ST_LOAD;
                            busy      <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (stop) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (terminal) begin
                        sweep_cnt <= sweep_next;
                        if (finish) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (mode[MODE_PP]) begin
                            dir <= ~dir;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_298a_sweep_ctrl.sv
// Directed bench for counter_298a_sweep_ctrl with a behavioural counter_298A closing the loop on cnt_q.
module tb_counter_298a_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, cfg_we, start, stop;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_data, y, cnt_d;
    logic       cnt_en, cnt_load, cnt_up, cnt_oe, busy, done, err;
    int         vecs = 0;
    int         errs = 0;

    always #5 clk = ~clk;

    counter_298a_sweep_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .stop(stop), .cnt_q(y), .cnt_en(cnt_en), .cnt_load(cnt_load),
        .cnt_up(cnt_up), .cnt_oe(cnt_oe), .cnt_d(cnt_d), .busy(busy), .done(done), .err(err)
    );

    // Behavioural counter_298A
    always @(posedge clk) begin
        if (cnt_load) y <= cnt_d;
        else if (cnt_en) y <= cnt_up ? y + 8'd1 : y - 8'd1;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_cfg(input logic [1:0] a, input logic [7:0] dat);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = dat;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic setup(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] reps, input logic [7:0] mode);
        write_cfg(2'd0, lo);
        write_cfg(2'd1, hi);
        write_cfg(2'd2, reps);
        write_cfg(2'd3, mode);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1; #1;
        vecs++;
        if ({cnt_en, cnt_load, cnt_up, cnt_oe, busy, done, err} !== 7'b0 || cnt_d !== 8'h00) begin
            errs++;
            $display("FAIL reset_outputs: got en/ld/up/oe/busy/done/err=%b d=%h, want all 0",
                     {cnt_en, cnt_load, cnt_up, cnt_oe, busy, done, err}, cnt_d);
        end
    endtask

    task automatic test_pingpong();
        logic [7:0] exp_q [7] = '{8'd3, 8'd4, 8'd5, 8'd6, 8'd5, 8'd4, 8'd3};
        setup(8'd3, 8'd6, 8'd2, 8'h03);
        start = 1'b1; #1;
        tick(); start = 1'b0; #1;
        vecs++;
        if (cnt_load !== 1'b1 || cnt_d !== 8'd3 || busy !== 1'b1) begin
            errs++; $display("FAIL pp_load: load=%b d=%h busy=%b, want 1 03 1", cnt_load, cnt_d, busy);
        end
        for (int i = 0; i < 7; i++) begin
            tick(); #1;
            vecs++;
            if (y !== exp_q[i]) begin
                errs++; $display("FAIL pp_q[%0d]: got %h want %h", i, y, exp_q[i]);
            end
            if (i == 3) begin
                vecs++;
                if ({cnt_en, cnt_up} !== 2'b10) begin
                    errs++; $display("FAIL pp_turn: en/up=%b want 10", {cnt_en, cnt_up});
                end
            end
        end
        tick(); #1;
        vecs++;
        if (done !== 1'b1 || busy !== 1'b0 || y !== 8'd3) begin
            errs++; $display("FAIL pp_done: done=%b busy=%b q=%h, want 1 0 03", done, busy, y);
        end
        tick(); #1;
        vecs++;
        if (done !== 1'b0 || y !== 8'd3) begin
            errs++; $display("FAIL pp_after: done=%b q=%h, want 0 03", done, y);
        end
    endtask

    task automatic test_sawtooth();
        logic [7:0] exp_q [6] = '{8'hFE, 8'hFF, 8'hFE, 8'hFF, 8'hFE, 8'hFF};
        logic       exp_ld [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        setup(8'hFE, 8'hFF, 8'd3, 8'h01);
        start = 1'b1; #1;
        tick(); start = 1'b0; #1;
        for (int i = 0; i < 6; i++) begin
            tick(); #1;
            vecs++;
            if (y !== exp_q[i] || cnt_load !== exp_ld[i] || done !== 1'b0) begin
                errs++; $display("FAIL saw_step[%0d]: q=%h load=%b done=%b, want %h %b 0",
                                 i, y, cnt_load, done, exp_q[i], exp_ld[i]);
            end
        end
        tick(); #1;
        vecs++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errs++; $display("FAIL saw_done: done=%b busy=%b, want 1 0", done, busy);
        end
    endtask

    task automatic test_stop();
        logic [7:0] exp_q [6] = '{8'd0, 8'd1, 8'd2, 8'd1, 8'd0, 8'd1};
        setup(8'd0, 8'd2, 8'd0, 8'h03);
        start = 1'b1; #1;
        tick(); start = 1'b0; #1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 5) stop = 1'b1;
            #1;
            vecs++;
            if (y !== exp_q[i] || busy !== 1'b1) begin
                errs++; $display("FAIL stop_q[%0d]: q=%h busy=%b, want %h 1", i, y, busy, exp_q[i]);
            end
        end
        vecs++;
        if ({cnt_en, cnt_load, cnt_up} !== 3'b000) begin
            errs++; $display("FAIL stop_ctrl: en/ld/up=%b want 000", {cnt_en, cnt_load, cnt_up});
        end
        tick(); stop = 1'b0; #1;
        vecs++;
        if (busy !== 1'b0 || done !== 1'b0 || y !== 8'd1) begin
            errs++; $display("FAIL stop_idle: busy=%b done=%b q=%h, want 0 0 01", busy, done, y);
        end
        tick(); #1;
        vecs++;
        if (done !== 1'b0 || y !== 8'd1) begin
            errs++; $display("FAIL stop_hold: done=%b q=%h, want 0 01", done, y);
        end
    endtask

    task automatic test_reject();
        setup(8'd9, 8'd2, 8'd0, 8'h01);
        start = 1'b1; #1;
        vecs++;
        if (cnt_load !== 1'b0) begin
            errs++; $display("FAIL rej_load0: load=%b want 0", cnt_load);
        end
        tick(); start = 1'b0; #1;
        vecs++;
        if (err !== 1'b1 || busy !== 1'b0 || cnt_load !== 1'b0) begin
            errs++; $display("FAIL rej_err: err=%b busy=%b load=%b, want 1 0 0", err, busy, cnt_load);
        end
        tick(); #1;
        vecs++;
        if (err !== 1'b0 || busy !== 1'b0 || cnt_load !== 1'b0) begin
            errs++; $display("FAIL rej_pulse: err=%b busy=%b load=%b, want 0 0 0", err, busy, cnt_load);
        end
        // LO becomes 1 (valid bounds), but the start shares the cycle with the write
        start = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd1;
        tick(); start = 1'b0; cfg_we = 1'b0; #1;
        vecs++;
        if (err !== 1'b0 || busy !== 1'b0 || cnt_load !== 1'b0) begin
            errs++; $display("FAIL rej_cfgwe: err=%b busy=%b load=%b, want 0 0 0", err, busy, cnt_load);
        end
    endtask

    task automatic test_degenerate();
        setup(8'd5, 8'd5, 8'd4, 8'h03);
        start = 1'b1; #1;
        tick(); start = 1'b0; #1;
        vecs++;
        if (cnt_load !== 1'b1 || cnt_d !== 8'd5) begin
            errs++; $display("FAIL deg_load: load=%b d=%h, want 1 05", cnt_load, cnt_d);
        end
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            vecs++;
            if (y !== 8'd5 || cnt_en !== 1'b0 || cnt_load !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                errs++; $display("FAIL deg_run[%0d]: q=%h en=%b load=%b busy=%b done=%b, want 05 0 0 1 0",
                                 i, y, cnt_en, cnt_load, busy, done);
            end
        end
        tick(); #1;
        vecs++;
        if (done !== 1'b1 || busy !== 1'b0 || y !== 8'd5) begin
            errs++; $display("FAIL deg_done: done=%b busy=%b q=%h, want 1 0 05", done, busy, y);
        end
    endtask

    task automatic test_busy_write_and_reset();
        setup(8'd0, 8'd4, 8'd1, 8'h05);
        start = 1'b1; #1;
        tick(); start = 1'b0; #1;
        tick(); #1;
        // Attempt to move HI to 3 while running; must be ignored
        write_cfg(2'd1, 8'd3); #1;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
        end
        vecs++;
        if (y !== 8'd4 || done !== 1'b0 || busy !== 1'b1) begin
            errs++; $display("FAIL bw_top: q=%h done=%b busy=%b, want 04 0 1", y, done, busy);
        end
        tick(); #1;
        vecs++;
        if (done !== 1'b1 || cnt_oe !== 1'b1) begin
            errs++; $display("FAIL bw_done: done=%b oe=%b, want 1 1", done, cnt_oe);
        end
        start = 1'b1; #1;
        tick(); start = 1'b0; #1;
        tick(); tick();
        rst_n = 1'b0;
        tick(); rst_n = 1'b1; #1;
        vecs++;
        if ({cnt_en, cnt_load, cnt_up, cnt_oe, busy, done, err} !== 7'b0 || cnt_d !== 8'h00) begin
            errs++; $display("FAIL rst_mid: en/ld/up/oe/busy/done/err=%b d=%h, want all 0",
                             {cnt_en, cnt_load, cnt_up, cnt_oe, busy, done, err}, cnt_d);
        end
        // Defaults: LO=0, HI=FF, REPS=0, up sawtooth
        start = 1'b1; #1;
        tick(); start = 1'b0; #1;
        vecs++;
        if (cnt_load !== 1'b1 || cnt_d !== 8'h00) begin
            errs++; $display("FAIL def_load: load=%b d=%h, want 1 00", cnt_load, cnt_d);
        end
        for (int i = 0; i < 256; i++) begin
            tick();
        end
        #1;
        vecs++;
        if (y !== 8'hFF || cnt_load !== 1'b1 || cnt_d !== 8'h00 || busy !== 1'b1) begin
            errs++; $display("FAIL def_wrap: q=%h load=%b d=%h busy=%b, want FF 1 00 1", y, cnt_load, cnt_d, busy);
        end
        tick(); #1;
        vecs++;
        if (y !== 8'h00 || done !== 1'b0 || busy !== 1'b1) begin
            errs++; $display("FAIL def_reload: q=%h done=%b busy=%b, want 00 0 1", y, done, busy);
        end
        stop = 1'b1;
        tick(); stop = 1'b0; #1;
    endtask

    initial begin
        y = 8'h00;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 8'h00; start = 1'b0; stop = 1'b0;
        @(negedge clk);
        test_reset();
        test_pingpong();
        test_sawtooth();
        test_stop();
        test_reject();
        test_degenerate();
        test_busy_write_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
